seg_scan_driver: RTL

Time-multiplexed driver for the board's eight seven-segment digits, split into two groups of four with separate segment buses. Takes eight BCD digits plus per-digit enable and decimal-point masks from the controller, latches them into a shadow set, and commits that set at frame boundaries so updates never tear. Scans one position per dwell period, with an anti-ghosting blank window. Decodes each digit with the team's BCD-to-segment encoding and drives the segment and anode pins directly.

---
 rtl/seg_scan_if.sv | 24 ++
 rtl/seg_scan_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: controller <-> display-driver bundle for seg_scan_driver.
// The master side (controller) supplies digits, masks and the load strobe.
// The slave side (driver) returns the segment buses, anodes and frame pulse.
interface seg_scan_if;
  logic [31:0] digits_bcd;
  logic [7:0]  digit_en;
  logic [7:0]  dp_mask;
  logic [7:0]  blink_mask;
  logic        load;
  logic [7:0]  seg_left;
  logic [7:0]  seg_right;
  logic [7:0]  an;
  logic        frame_done;

  modport master (
    output digits_bcd, digit_en, dp_mask, blink_mask, load,
    input  seg_left, seg_right, an, frame_done
  );

  modport slave (
    input  digits_bcd, digit_en, dp_mask, blink_mask, load,
    output seg_left, seg_right, an, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for eight seven-segment digits
// arranged as two groups of four (digits 7..4 on seg_left, 3..0 on seg_right).
// Digit data is captured into a pending set on load and committed to the
// active set only at a frame boundary, so a frame is never torn by an update.
// Each of the four scan positions lasts DWELL_CYCLES clocks and starts with a
// BLANK_CYCLES window where every anode and segment is off (anti-ghosting).
// Optional feature macro: SEG_BLINK_EN adds per-digit blinking with a half
// period of BLINK_FRAMES frames. Without it blink_mask is latched but unused.
module seg_scan_driver #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_scan_if.slave bus
);

  localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  // One complete set of display data; pending and active hold one each.
  typedef struct packed {
    logic [31:0] bcd;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic [7:0]  blink;
  } shadow_t;

  // Team BCD-to-segment encoding: bit7=a .. bit1=g, bit0=dp; 10..15 show a dash.
  function automatic logic [7:0] seg_encode(input logic [3:0] bcd_s);
    logic [7:0] pat_s;
    case (bcd_s)
      4'd0:    pat_s = 8'hFC;
      4'd1:    pat_s = 8'h60;
      4'd2:    pat_s = 8'hDA;
      4'd3:    pat_s = 8'hF2;
      4'd4:    pat_s = 8'h66;
      4'd5:    pat_s = 8'hB6;
      4'd6:    pat_s = 8'hBE;
      4'd7:    pat_s = 8'hE0;
      4'd8:    pat_s = 8'hFE;
      4'd9:    pat_s = 8'hE6;
      default: pat_s = 8'h02;
    endcase
    return pat_s;
  endfunction

  // Full pattern for one digit: blanked when disabled or hidden by blinking.
  function automatic logic [7:0] digit_pattern(
    input logic [3:0] bcd_s,
    input logic       en_s,
    input logic       dp_s,
    input logic       hide_s
  );
    logic [7:0] pat_s;
    if (en_s && !hide_s) begin
      pat_s = seg_encode(bcd_s) | {7'b000_0000, dp_s};
    end else begin
      pat_s = 8'h00;
    end
    return pat_s;
  endfunction

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  shadow_t       pending_r;
  shadow_t       active_r;
  logic [7:0]    an_r;
  logic [7:0]    seg_left_r;
  logic [7:0]    seg_right_r;
  logic          frame_done_r;

  logic          boundary_s;
  logic          blank_s;
  shadow_t       load_set_s;
  logic [4:0]    right_base_s;
  logic [4:0]    left_base_s;
  logic [2:0]    right_sel_s;
  logic [2:0]    left_sel_s;
  logic          hide_right_s;
  logic          hide_left_s;
  logic [7:0]    an_next_s;
  logic [7:0]    seg_left_next_s;
  logic [7:0]    seg_right_next_s;

  assign boundary_s   = (cnt_r == CNT_LAST) && (idx_r == 2'd3);
  assign blank_s      = (cnt_r < BLANK_LIM);
  assign load_set_s   = '{bcd:   bus.digits_bcd,
                          en:    bus.digit_en,
                          dp:    bus.dp_mask,
                          blink: bus.blink_mask};
  assign right_base_s = {1'b0, idx_r, 2'b00};
  assign left_base_s  = {1'b1, idx_r, 2'b00};
  assign right_sel_s  = {1'b0, idx_r};
  assign left_sel_s   = {1'b1, idx_r};

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

  logic [FW-1:0] frame_cnt_r;
  logic          blink_phase_r;

  // Count committed frames; flip the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (boundary_s) begin
      if (frame_cnt_r == FRAME_LAST) begin
        frame_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r   <= frame_cnt_r + FRAME_ONE;
      end
    end
  end

  assign hide_right_s = blink_phase_r & active_r.blink[right_sel_s];
  assign hide_left_s  = blink_phase_r & active_r.blink[left_sel_s];
`else
  // Blink data is captured for software visibility but never shown.
  logic unused_blink_s;
  assign unused_blink_s = ^{active_r.blink, (BLINK_FRAMES > 0)};
  assign hide_right_s   = 1'b0;
  assign hide_left_s    = 1'b0;
`endif

  // Dwell counter and scan position; idx wraps 3 -> 0 naturally in 2 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Shadow sets: load fills pending; the frame boundary commits to active,
  // and a load on the boundary itself bypasses straight into active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
      active_r  <= '0;
    end else begin
      if (bus.load) begin
        pending_r <= load_set_s;
      end
      if (boundary_s) begin
        active_r <= bus.load ? load_set_s : pending_r;
      end
    end
  end

  // Next output values derived from the current scan state and active set.
  always_comb begin
    an_next_s        = 8'h00;
    seg_left_next_s  = 8'h00;
    seg_right_next_s = 8'h00;
    if (blank_s) begin
      an_next_s        = 8'h00;
      seg_left_next_s  = 8'h00;
      seg_right_next_s = 8'h00;
    end else begin
      an_next_s        = 8'h11 << idx_r;
      seg_right_next_s = digit_pattern(active_r.bcd[right_base_s +: 4],
                                       active_r.en[right_sel_s],
                                       active_r.dp[right_sel_s],
                                       hide_right_s);
      seg_left_next_s  = digit_pattern(active_r.bcd[left_base_s +: 4],
                                       active_r.en[left_sel_s],
                                       active_r.dp[left_sel_s],
                                       hide_left_s);
    end
  end

  // Registered pin drivers; frame_done pulses the cycle after the boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r         <= 8'h00;
      seg_left_r   <= 8'h00;
      seg_right_r  <= 8'h00;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_next_s;
      seg_left_r   <= seg_left_next_s;
      seg_right_r  <= seg_right_next_s;
      frame_done_r <= boundary_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.seg_left   = seg_left_r;
  assign bus.seg_right  = seg_right_r;
  assign bus.frame_done = frame_done_r;

endmodule
